// File: rtl/ucode_decode.sv
// Microinstruction decode stage: registers the sequencer word, decodes strobes/selects,
// and owns the PC, AR, IR and LED registers. Optional trap mode: define UDEC_ILLEGAL_TRAP_EN.
module ucode_decode #(
  parameter logic [7:0] PC_RST = 8'h00
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [25:0] ucode,
  input  logic [7:0]  bus_in,
  output logic [14:0] ld,
  output logic [11:0] bus_sel,
  output logic        ram_we,
  output logic [3:0]  alu_s,
  output logic        alu_m,
  output logic        dispatch,
  output logic [7:0]  pc_out,
  output logic [7:0]  ar_out,
  output logic [7:0]  ir_out,
  output logic [7:0]  led_out,
  output logic        err
);

  localparam logic [3:0] ALdram  = 4'd9;
  localparam logic [3:0] ALdramd = 4'd10;
  localparam logic [3:0] ALdpc   = 4'd11;
  localparam logic [3:0] AIncpc  = 4'd12;
  localparam logic [3:0] ALdled  = 4'd13;
  localparam logic [3:0] ALdir   = 4'd14;
  localparam logic [3:0] AIllegal = 4'd15;
  localparam logic [3:0] CP1     = 4'd1;

  logic [25:0] uw_q;
  logic [7:0]  pc_q, ar_q, ir_q, led_q;
  logic [3:0]  a_f, b_f, c_f;
  logic        we_f;
  logic        freeze;
  logic        act;
  logic        illegal;
  logic        unused_ua;

  assign a_f  = uw_q[19:16];
  assign b_f  = uw_q[15:12];
  assign c_f  = uw_q[11:8];
  assign we_f = uw_q[20];
  assign unused_ua = ^uw_q[7:0];

  assign illegal = (a_f == AIllegal) || (b_f > 4'd11);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      uw_q <= 26'b0;
    end else if (en) begin
      uw_q <= ucode;
    end
  end

`ifdef UDEC_ILLEGAL_TRAP_EN
  logic err_q;

  // Sticky: once set, everything that can change machine state is blocked until reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (en && illegal) begin
      err_q <= 1'b1;
    end
  end

  assign freeze = err_q;
  assign err    = err_q;
`else
  logic unused_illegal;
  assign unused_illegal = illegal;
  assign freeze = 1'b0;
  assign err    = 1'b0;
`endif

  assign act = en && !freeze;

  always_comb begin
    ld = 15'd0;
    if (act && (a_f != 4'd0) && (a_f != AIllegal)) begin
      ld = 15'd1 << a_f;
    end
  end

  always_comb begin
    bus_sel = 12'd0;
    if (b_f < 4'd12) begin
      bus_sel = 12'd1 << b_f;
    end
  end

  assign ram_we   = act && we_f && (a_f == ALdram);
  assign dispatch = act && (c_f == CP1);
  assign alu_s    = uw_q[25:22];
  assign alu_m    = uw_q[21];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q  <= PC_RST;
      ar_q  <= 8'h00;
      ir_q  <= 8'h00;
      led_q <= 8'h00;
    end else if (act) begin
      unique case (a_f)
        ALdpc:   pc_q  <= bus_in;
        AIncpc:  pc_q  <= pc_q + 8'd1;
        ALdramd: ar_q  <= bus_in;
        ALdir:   ir_q  <= bus_in;
        ALdled:  led_q <= bus_in;
        default: ;
      endcase
    end
  end

  assign pc_out  = pc_q;
  assign ar_out  = ar_q;
  assign ir_out  = ir_q;
  assign led_out = led_q;

endmodule

// File: tb/tb_ucode_decode.sv
// Scoreboard bench for ucode_decode: stimulus pushes expected outputs from a behavioural
// model, a monitor pops and compares them each cycle.
module tb_ucode_decode;

  localparam logic [7:0] PCR = 8'h5A;

  logic        clk, rst, en;
  logic [25:0] ucode;
  logic [7:0]  bus_in;
  logic [14:0] ld;
  logic [11:0] bus_sel;
  logic        ram_we, alu_m, dispatch, err;
  logic [3:0]  alu_s;
  logic [7:0]  pc_out, ar_out, ir_out, led_out;

  ucode_decode #(.PC_RST(PCR)) dut (
    .clk(clk), .rst(rst), .en(en), .ucode(ucode), .bus_in(bus_in),
    .ld(ld), .bus_sel(bus_sel), .ram_we(ram_we), .alu_s(alu_s), .alu_m(alu_m),
    .dispatch(dispatch), .pc_out(pc_out), .ar_out(ar_out), .ir_out(ir_out),
    .led_out(led_out), .err(err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic        en;
    logic [14:0] ld;
    logic [11:0] bus_sel;
    logic        ram_we;
    logic [3:0]  s;
    logic        m;
    logic        disp;
    logic [7:0]  pc, ar, ir, led;
    logic        err;
  } exp_t;

  exp_t q[$];
  int n_chk = 0;
  int n_fail = 0;

`ifdef UDEC_ILLEGAL_TRAP_EN
  localparam bit Trap = 1'b1;
`else
  localparam bit Trap = 1'b0;
`endif

  // Behavioural model state
  logic [25:0] m_uw;
  logic [7:0]  m_pc, m_ar, m_ir, m_led;
  logic        m_err;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_chk++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, expv, $time);
    end
  endtask

  function automatic logic [25:0] mk(input int s, input int m, input int we, input int a,
                                     input int b, input int c, input int ua);
    logic [25:0] w;
    w = {s[3:0], m[0], we[0], a[3:0], b[3:0], c[3:0], ua[7:0]};
    return w;
  endfunction

  task automatic model_reset();
    m_uw = 26'd0; m_pc = PCR; m_ar = 8'd0; m_ir = 8'd0; m_led = 8'd0; m_err = 1'b0;
  endtask

  task automatic cycle(input logic e, input logic [25:0] w, input logic [7:0] bi);
    exp_t x;
    int a, b, c;
    bit live;
    @(negedge clk);
    en = e; ucode = w; bus_in = bi;
    a = int'(m_uw[19:16]); b = int'(m_uw[15:12]); c = int'(m_uw[11:8]);
    live = e && !(Trap && m_err);
    x.en      = e;
    x.ld      = (live && a >= 1 && a <= 14) ? 15'(1 << a) : 15'd0;
    x.bus_sel = (b <= 11) ? 12'(1 << b) : 12'd0;
    x.ram_we  = live && m_uw[20] && a == 9;
    x.s       = m_uw[25:22];
    x.m       = m_uw[21];
    x.disp    = live && c == 1;
    x.pc = m_pc; x.ar = m_ar; x.ir = m_ir; x.led = m_led;
    x.err     = Trap && m_err;
    q.push_back(x);
    // Effect of the coming edge
    if (live) begin
      if (a == 11) m_pc = bi;
      if (a == 12) m_pc = 8'((int'(m_pc) + 1) % 256);
      if (a == 10) m_ar = bi;
      if (a == 14) m_ir = bi;
      if (a == 13) m_led = bi;
    end
    if (Trap && e && (a == 15 || b >= 12)) m_err = 1'b1;
    if (e) m_uw = w;
  endtask

  // Monitor
  initial begin
    exp_t x;
    forever begin
      @(negedge clk);
      #1;
      if (q.size() > 0) begin
        x = q.pop_front();
        check("ld", 32'(ld), 32'(x.ld));
        check("ram_we", 32'(ram_we), 32'(x.ram_we));
        check("alu_s", 32'(alu_s), 32'(x.s));
        check("alu_m", 32'(alu_m), 32'(x.m));
        check("pc", 32'(pc_out), 32'(x.pc));
        check("ar", 32'(ar_out), 32'(x.ar));
        check("ir", 32'(ir_out), 32'(x.ir));
        check("led", 32'(led_out), 32'(x.led));
        check("err", 32'(err), 32'(x.err));
        if (x.en) begin
          check("bus_sel", 32'(bus_sel), 32'(x.bus_sel));
          check("dispatch", 32'(dispatch), 32'(x.disp));
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish, n_chk=%0d", n_chk);
    $fatal(1);
  end

  task automatic reset_checks(input string tag);
    check({tag, "_pc"}, 32'(pc_out), 32'(PCR));
    check({tag, "_ar"}, 32'(ar_out), 32'd0);
    check({tag, "_ld"}, 32'(ld), 32'd0);
    check({tag, "_bus_sel"}, 32'(bus_sel), 32'h001);
    check({tag, "_ram_we"}, 32'(ram_we), 32'd0);
    check({tag, "_err"}, 32'(err), 32'd0);
  endtask

  initial begin
    logic [7:0] pc_before;
    rst = 1'b1; en = 1'b0; ucode = 26'd0; bus_in = 8'd0;
    model_reset();
    repeat (2) @(negedge clk);
    reset_checks("reset");
    rst = 1'b0;

    cycle(1'b1, 26'd0, 8'h00);
    // LDRAMD from PC_B source
    cycle(1'b1, mk(0, 0, 0, 10, 11, 0, 0), 8'h00);
    cycle(1'b1, 26'd0, 8'h3C);
    cycle(1'b1, 26'd0, 8'h00);
    #2 check("ar_load", 32'(ar_out), 32'h3C);
    // PC wrap
    cycle(1'b1, mk(0, 0, 0, 11, 0, 0, 0), 8'h00);
    cycle(1'b1, mk(0, 0, 0, 12, 0, 1, 0), 8'hFF);
    cycle(1'b1, 26'd0, 8'h00);
    cycle(1'b1, 26'd0, 8'h00);
    #2 check("pc_wrap", 32'(pc_out), 32'h00);
    // ram_we only with LDRAM
    cycle(1'b1, mk(3, 1, 1, 9, 2, 0, 0), 8'h00);
    cycle(1'b1, mk(5, 0, 1, 13, 4, 0, 0), 8'h00);
    cycle(1'b1, 26'd0, 8'hA7);
    cycle(1'b1, 26'd0, 8'h00);
    #2 check("led_load", 32'(led_out), 32'hA7);
    // en low holds LDIR word
    cycle(1'b1, mk(0, 0, 0, 14, 1, 0, 0), 8'h00);
    repeat (3) cycle(1'b0, mk(0, 0, 0, 12, 0, 0, 0), 8'h11);
    cycle(1'b1, 26'd0, 8'h77);
    cycle(1'b1, 26'd0, 8'h00);
    #2 check("ir_after_en", 32'(ir_out), 32'h77);
    // Illegal A then INCPC
    pc_before = m_pc;
    cycle(1'b1, mk(0, 0, 0, 15, 0, 0, 0), 8'h00);
    cycle(1'b1, mk(0, 0, 0, 12, 0, 0, 0), 8'h00);
    cycle(1'b1, 26'd0, 8'h00);
    cycle(1'b1, 26'd0, 8'h00);
    #2;
    check("illegal_err", 32'(err), Trap ? 32'd1 : 32'd0);
    check("illegal_pc", 32'(pc_out), Trap ? 32'(pc_before) : 32'(pc_before + 8'd1));

    // Mid-operation asynchronous reset with a pending PC write
    cycle(1'b1, mk(0, 0, 0, 11, 0, 0, 0), 8'h00);
    @(negedge clk);
    #1;
    while (q.size() > 0) void'(q.pop_front());
    bus_in = 8'hEE;
    #1 rst = 1'b1;
    #1 reset_checks("mid_reset");
    model_reset();
    en = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    cycle(1'b1, 26'd0, 8'h00);

    for (int i = 0; i < 3000; i++) begin
      int a, b;
      if (i == 1500) begin
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        en = 1'b0;
      end
      a = ($urandom_range(0, 29) == 0) ? 15 : $urandom_range(0, 14);
      b = ($urandom_range(0, 29) == 0) ? $urandom_range(12, 15) : $urandom_range(0, 11);
      cycle($urandom_range(0, 4) != 0,
            mk($urandom_range(0, 15), $urandom_range(0, 1), $urandom_range(0, 1), a, b,
               $urandom_range(0, 3), $urandom_range(0, 255)),
            8'($urandom_range(0, 255)));
    end
    repeat (2) @(negedge clk);
    #2 check("queue_drained", 32'(q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
